// File: rtl/stream_mm_write_bridge.sv
// stream_mm_write_bridge: packs a serial bit stream into words, buffers them
// in a FIFO and writes them to an Avalon-MM slave at incrementing addresses.
module stream_mm_write_bridge #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 25,
   parameter int FIFO_DEPTH = 16,
   parameter int BASE_ADDR  = 0,
   parameter int WORD_LIMIT = 512,
   parameter int LSB_FIRST  = 1
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                Start,
   input  logic                Bit_Valid,
   input  logic                Bit_Data,
   output logic                Bit_Ready,
   input  logic                Frame_End,
   output logic [ADDR_W-1:0]   Avalon_Address,
   output logic [DATA_W/8-1:0] Avalon_ByteEnable,
   output logic [DATA_W-1:0]   Avalon_WriteData,
   output logic                Avalon_Write,
   input  logic                Avalon_WaitRequest,
   output logic                Busy,
   output logic                Overflow,
   output logic                Wrapped,
   output logic [ADDR_W-1:0]   Words_Written
);
   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = $clog2(DATA_W);
   localparam int CNT_W = IDX_W + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = BE_W + DATA_W;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + WORD_LIMIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DRAIN} state_t;

   // packer
   logic [DATA_W-1:0] word_q, word_d, pword;
   logic [CNT_W-1:0]  cnt_q, cnt_d, nbits;
   logic [IDX_W-1:0]  pos;
   logic [BE_W-1:0]   pbe;
   logic              push;

   // fifo
   logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W:0]    wp_q, wp_d, rp_q, rp_d;
   logic [ENT_W-1:0]  head;
   logic              full, empty, pop, wr_en, ovf_set;

   // writer
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, words_q, words_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic              write_q, write_d;
   logic              wrap_q, wrap_d, ovf_q, ovf_d;
   logic              accept;

   always_comb begin
      pos   = (LSB_FIRST != 0) ? cnt_q[IDX_W-1:0]
                               : IDX_W'(DATA_W - 1) - cnt_q[IDX_W-1:0];
      pword = word_q;
      nbits = cnt_q;
      if (Bit_Valid) begin
         pword[pos] = Bit_Data;
         nbits      = cnt_q + 1'b1;
      end
      // a lane is enabled once it holds at least one received bit
      pbe = '0;
      for (int i = 0; i < BE_W; i++) begin
         if (LSB_FIRST != 0) pbe[i] = int'(nbits) > 8 * i;
         else                pbe[i] = int'(nbits) + 8 * i + 7 >= DATA_W;
      end
      push = !Start && (nbits == CNT_W'(DATA_W) ||
                        (Frame_End && nbits != '0));
      word_d = (push || Start) ? '0 : pword;
      cnt_d  = (push || Start) ? '0 : nbits;
   end

   assign empty   = wp_q == rp_q;
   assign full    = (wp_q[PTR_W] != rp_q[PTR_W]) &&
                    (wp_q[PTR_W-1:0] == rp_q[PTR_W-1:0]);
   assign head    = mem_q[rp_q[PTR_W-1:0]];
   assign wr_en   = push && (!full || pop);
   assign ovf_set = push && full && !pop;
   assign wp_d    = Start ? '0 : wp_q + (PTR_W+1)'(wr_en);
   assign rp_d    = Start ? '0 : rp_q + (PTR_W+1)'(pop);

   always_ff @(posedge Clk) begin
      if (wr_en) mem_q[wp_q[PTR_W-1:0]] <= {pbe, pword};
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (!Start && !empty) state_d = S_WRITE;
         S_WRITE:
            if (!Avalon_WaitRequest)
               state_d = (!Start && !empty) ? S_WRITE : S_IDLE;
            else if (Start)
               state_d = S_DRAIN;
         S_DRAIN:
            if (!Avalon_WaitRequest) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      accept  = write_q && !Avalon_WaitRequest;
      pop     = !Start && !empty &&
                (state_q == S_IDLE ||
                 (state_q == S_WRITE && !Avalon_WaitRequest));
      addr_d  = addr_q;
      data_d  = data_q;
      be_d    = be_q;
      write_d = write_q;
      words_d = words_q;
      wrap_d  = wrap_q;
      ovf_d   = ovf_q | ovf_set;
      if (pop) begin
         {be_d, data_d} = head;
         write_d        = 1'b1;
      end else if (accept) begin
         write_d = 1'b0;
      end
      if (state_q == S_WRITE && accept) begin
         if (words_q != '1) words_d = words_q + 1'b1;
         if (addr_q == LAST) begin
            addr_d = BASE;
            wrap_d = 1'b1;
         end else begin
            addr_d = addr_q + 1'b1;
         end
      end
      if (state_q == S_DRAIN && accept) addr_d = BASE;
      // a stalled beat keeps its address until the slave takes it
      if (Start) begin
         words_d = '0;
         wrap_d  = 1'b0;
         ovf_d   = 1'b0;
         if (!(write_q && Avalon_WaitRequest)) addr_d = BASE;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         word_q  <= '0;
         cnt_q   <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         addr_q  <= BASE;
         data_q  <= '0;
         be_q    <= '0;
         write_q <= 1'b0;
         words_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         be_q    <= be_d;
         write_q <= write_d;
         words_q <= words_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign Bit_Ready         = !full;
   assign Avalon_Address    = addr_q;
   assign Avalon_ByteEnable = be_q;
   assign Avalon_WriteData  = data_q;
   assign Avalon_Write      = write_q;
   assign Overflow          = ovf_q;
   assign Wrapped           = wrap_q;
   assign Words_Written     = words_q;
   assign Busy = write_q | !empty | (cnt_q != '0) | (state_q == S_DRAIN);

endmodule

// File: tb/tb_stream_mm_write_bridge.sv
// Directed bench for stream_mm_write_bridge: packing, flush byte enables,
// stalls, address wrap, overflow, Start mid-beat and async reset.
module tb_stream_mm_write_bridge;
   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 4;

   logic          Clk = 1'b0;
   logic          Reset_n, Start, Bit_Valid, Bit_Data, Frame_End;
   logic          Bit_Ready, Avalon_Write, Avalon_WaitRequest;
   logic          Busy, Overflow, Wrapped;
   logic [AW-1:0] Avalon_Address, Words_Written;
   logic [1:0]    Avalon_ByteEnable;
   logic [DW-1:0] Avalon_WriteData;

   int n_checks = 0;
   int n_errors = 0;
   logic [25:0] beats[$];

   stream_mm_write_bridge #(
      .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH),
      .BASE_ADDR(0), .WORD_LIMIT(4), .LSB_FIRST(1)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
      .Bit_Valid(Bit_Valid), .Bit_Data(Bit_Data),
      .Bit_Ready(Bit_Ready), .Frame_End(Frame_End),
      .Avalon_Address(Avalon_Address),
      .Avalon_ByteEnable(Avalon_ByteEnable),
      .Avalon_WriteData(Avalon_WriteData),
      .Avalon_Write(Avalon_Write),
      .Avalon_WaitRequest(Avalon_WaitRequest),
      .Busy(Busy), .Overflow(Overflow), .Wrapped(Wrapped),
      .Words_Written(Words_Written)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk)
      if (Reset_n && Avalon_Write && !Avalon_WaitRequest)
         beats.push_back({Avalon_Address, Avalon_WriteData,
                          Avalon_ByteEnable});

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_beat(input string tag, input int idx,
                             input logic [7:0] a, input logic [15:0] d,
                             input logic [1:0] b);
      logic [25:0] e;
      e = (idx < beats.size()) ? beats[idx] : '1;
      check(tag, 64'(e), 64'({a, d, b}));
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic send_bits(input logic [15:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         Bit_Valid = 1'b1;
         Bit_Data  = w[i];
         tick();
      end
      Bit_Valid = 1'b0;
      Bit_Data  = 1'b0;
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic frame_end();
      Frame_End = 1'b1;
      tick();
      Frame_End = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (Busy && k < 200) begin
         tick();
         k++;
      end
      check(tag, 64'(Busy), 64'(0));
   endtask

   initial begin
      Reset_n = 1'b0;
      Start = 1'b0;
      Bit_Valid = 1'b0;
      Bit_Data = 1'b0;
      Frame_End = 1'b0;
      Avalon_WaitRequest = 1'b0;
      tick();
      tick();
      check("rst_addr", 64'(Avalon_Address), 64'(0));
      check("rst_write", 64'(Avalon_Write), 64'(0));
      check("rst_ready", 64'(Bit_Ready), 64'(1));
      check("rst_busy", 64'(Busy), 64'(0));
      check("rst_flags", 64'({Overflow, Wrapped}), 64'(0));
      check("rst_ww", 64'(Words_Written), 64'(0));
      check("rst_data_be", 64'({Avalon_WriteData, Avalon_ByteEnable}), 64'(0));
      Reset_n = 1'b1;
      tick();

      // T1: two full words, no stall
      pulse_start();
      beats.delete();
      send_bits(16'h1234, 16);
      check("t1_latency0", 64'(Avalon_Write), 64'(0));
      tick();
      check("t1_latency1", 64'({Avalon_Write, Avalon_Address,
                                Avalon_WriteData}), 64'({1'b1, 8'd0, 16'h1234}));
      send_bits(16'hABCD, 16);
      wait_idle("t1_idle");
      check("t1_nbeats", 64'(beats.size()), 64'(2));
      check_beat("t1_beat0", 0, 8'd0, 16'h1234, 2'b11);
      check_beat("t1_beat1", 1, 8'd1, 16'hABCD, 2'b11);
      check("t1_ww", 64'(Words_Written), 64'(2));

      // T2: five stall cycles on the first beat
      pulse_start();
      beats.delete();
      Avalon_WaitRequest = 1'b1;
      send_bits(16'h5A5A, 16);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t2_hold", 64'({Avalon_Write, Avalon_Address, Avalon_WriteData}),
               64'({1'b1, 8'd0, 16'h5A5A}));
         tick();
      end
      Avalon_WaitRequest = 1'b0;
      wait_idle("t2_idle");
      check("t2_nbeats", 64'(beats.size()), 64'(1));
      check_beat("t2_beat0", 0, 8'd0, 16'h5A5A, 2'b11);
      check("t2_ww", 64'(Words_Written), 64'(1));

      // T3: partial-word flushes
      pulse_start();
      beats.delete();
      send_bits(16'h1111, 16);
      send_bits(16'h0009, 4);
      frame_end();
      send_bits(16'h0ABC, 12);
      frame_end();
      send_bits(16'h00C3, 7);
      Bit_Valid = 1'b1;
      Bit_Data = 1'b1;
      Frame_End = 1'b1;
      tick();
      Bit_Valid = 1'b0;
      Bit_Data = 1'b0;
      Frame_End = 1'b0;
      wait_idle("t3_idle");
      frame_end();
      tick();
      check("t3_nbeats", 64'(beats.size()), 64'(4));
      check_beat("t3_full", 0, 8'd0, 16'h1111, 2'b11);
      check_beat("t3_4bits", 1, 8'd1, 16'h0009, 2'b01);
      check_beat("t3_12bits", 2, 8'd2, 16'h0ABC, 2'b11);
      check_beat("t3_8bits_fe", 3, 8'd3, 16'h00C3, 2'b01);
      check("t3_busy", 64'(Busy), 64'(0));

      // T4: wrap after four words
      pulse_start();
      beats.delete();
      check("t4_wrap_clr", 64'(Wrapped), 64'(0));
      for (int i = 0; i < 3; i++) send_bits(16'h1000 + 16'(i), 16);
      wait_idle("t4_idle0");
      check("t4_wrap0", 64'({Wrapped, Avalon_Address}), 64'({1'b0, 8'd3}));
      send_bits(16'h1003, 16);
      wait_idle("t4_idle1");
      check("t4_wrap1", 64'({Wrapped, Avalon_Address}), 64'({1'b1, 8'd0}));
      send_bits(16'h1004, 16);
      send_bits(16'h1005, 16);
      wait_idle("t4_idle2");
      check("t4_nbeats", 64'(beats.size()), 64'(6));
      check_beat("t4_b3", 3, 8'd3, 16'h1003, 2'b11);
      check_beat("t4_b4", 4, 8'd0, 16'h1004, 2'b11);
      check_beat("t4_b5", 5, 8'd1, 16'h1005, 2'b11);
      check("t4_ww", 64'(Words_Written), 64'(6));

      // T5: stalled beat in flight, then DEPTH+2 more words
      pulse_start();
      beats.delete();
      Avalon_WaitRequest = 1'b1;
      send_bits(16'hA000, 16);
      tick();
      for (int i = 1; i <= DEPTH + 2; i++) begin
         send_bits(16'hA000 + 16'(i), 16);
         if (i == DEPTH) begin
            check("t5_ready_full", 64'(Bit_Ready), 64'(0));
            check("t5_no_ovf_yet", 64'(Overflow), 64'(0));
         end
      end
      check("t5_ovf", 64'(Overflow), 64'(1));
      Avalon_WaitRequest = 1'b0;
      wait_idle("t5_idle");
      check("t5_nbeats", 64'(beats.size()), 64'(DEPTH + 1));
      check_beat("t5_first", 0, 8'd0, 16'hA000, 2'b11);
      check_beat("t5_last", DEPTH, 8'd0, 16'hA000 + 16'(DEPTH), 2'b11);
      check("t5_ww", 64'(Words_Written), 64'(DEPTH + 1));
      check("t5_ready_back", 64'(Bit_Ready), 64'(1));

      // T6: Start while a beat is stalled
      pulse_start();
      beats.delete();
      check("t6_ovf_clr", 64'(Overflow), 64'(0));
      send_bits(16'h0101, 16);
      send_bits(16'h0202, 16);
      wait_idle("t6_idle0");
      Avalon_WaitRequest = 1'b1;
      send_bits(16'h0303, 16);
      tick();
      send_bits(16'h0404, 16);
      pulse_start();
      check("t6_held", 64'({Avalon_Write, Avalon_Address, Avalon_WriteData}),
            64'({1'b1, 8'd2, 16'h0303}));
      check("t6_ww_clr", 64'(Words_Written), 64'(0));
      check("t6_busy", 64'(Busy), 64'(1));
      tick();
      tick();
      Avalon_WaitRequest = 1'b0;
      tick();
      check("t6_done", 64'({Avalon_Write, Avalon_Address}), 64'({1'b0, 8'd0}));
      tick();
      tick();
      check("t6_no_more", 64'(Avalon_Write), 64'(0));
      check("t6_nbeats", 64'(beats.size()), 64'(3));
      check_beat("t6_drain", 2, 8'd2, 16'h0303, 2'b11);
      check("t6_ww", 64'(Words_Written), 64'(0));
      check("t6_idle", 64'(Busy), 64'(0));

      // async reset during a stalled burst
      Avalon_WaitRequest = 1'b1;
      send_bits(16'h0505, 16);
      tick();
      check("rst_pre", 64'(Avalon_Write), 64'(1));
      Reset_n = 1'b0;
      #1;
      check("rst_async", 64'({Avalon_Write, Avalon_Address, Bit_Ready}),
            64'({1'b0, 8'd0, 1'b1}));
      tick();
      Reset_n = 1'b1;
      Avalon_WaitRequest = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
